// File: rtl/march_bist_controller_if.sv
// RAM-side access bundle between the BIST sequencer and the functional/BIST mux.
interface march_bist_controller_if #(
    parameter int SIZE   = 6,
    parameter int LENGTH = 8
);
    logic              mem_cs;
    logic              mem_rwbar;
    logic [SIZE-1:0]   mem_addr;
    logic [LENGTH-1:0] mem_wdata;
    logic [LENGTH-1:0] mem_rdata;

    modport master (
        output mem_cs,
        output mem_rwbar,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs,
        input  mem_rwbar,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/march_bist_controller.sv
// March C- BIST sequencer: one RAM op per cycle, same-cycle read compare,
// sticky fail flag with capture of the first mismatching address and element.
module march_bist_controller #(
    parameter int SIZE   = 6,
    parameter int LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    march_bist_controller_if.master mem,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [SIZE-1:0]         fail_addr,
    output logic [2:0]              fail_element
);
    // state | meaning
    // IDLE  | waiting for start; capture registers hold last result
    // RUN   | one march operation per cycle
    // DONE  | test finished; waits for start to drop before re-arming

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic logic [LENGTH-1:0] alt_pattern();
        logic [LENGTH-1:0] p;
        for (int i = 0; i < LENGTH; i++) p[i] = ((LENGTH - 1 - i) % 2) == 0;
        return p;
    endfunction

    localparam logic [LENGTH-1:0] D0        = alt_pattern();
    localparam logic [LENGTH-1:0] D1        = ~D0;
    localparam logic [SIZE-1:0]   ADDR_MAX  = {SIZE{1'b1}};
    localparam logic [SIZE-1:0]   ADDR_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [2:0]        LAST_ELEM = 3'd5;

    state_t            state, state_nxt;
    logic [2:0]        element;
    logic              op;
    logic [SIZE-1:0]   addr;

    logic              is_read;
    logic              elem_dn;
    logic              next_elem_dn;
    logic              last_op;
    logic              last_addr;
    logic              last_step;
    logic              mismatch;
    logic [LENGTH-1:0] op_data;

    // M0 and M5 hold a single op; M1..M4 are read-then-write at each address.
    always_comb begin
        elem_dn      = (element == 3'd3) || (element == 3'd4);
        next_elem_dn = (element == 3'd2) || (element == 3'd3);
        is_read      = (element == LAST_ELEM) || ((element != 3'd0) && !op);
        last_op      = (element == 3'd0) || (element == LAST_ELEM) || op;
        last_addr    = elem_dn ? (addr == '0) : (addr == ADDR_MAX);
        last_step    = last_op && last_addr && (element == LAST_ELEM);
        if (is_read) op_data = ((element == 3'd2) || (element == 3'd4)) ? D1 : D0;
        else         op_data = ((element == 3'd1) || (element == 3'd3)) ? D1 : D0;
        mismatch     = (state == ST_RUN) && is_read && (mem.mem_rdata != op_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (!start)    state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            element      <= '0;
            op           <= 1'b0;
            addr         <= '0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= '0;
        end else if ((state == ST_IDLE) && start) begin
            element      <= '0;
            op           <= 1'b0;
            addr         <= '0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= '0;
        end else if (state == ST_RUN) begin
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr    <= addr;
                    fail_element <= element;
                end
            end
            if (!last_op) begin
                op <= 1'b1;
            end else begin
                op <= 1'b0;
                if (!last_addr) begin
                    addr <= elem_dn ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
                end else if (element != LAST_ELEM) begin
                    element <= element + 3'd1;
                    addr    <= next_elem_dn ? ADDR_MAX : '0;
                end
            end
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_cs    = 1'b0;
        mem.mem_rwbar = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            ST_RUN: begin
                busy          = 1'b1;
                mem.mem_cs    = 1'b1;
                mem.mem_rwbar = is_read;
                mem.mem_addr  = addr;
                mem.mem_wdata = is_read ? '0 : op_data;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_march_bist_controller.sv
// Bench for march_bist_controller: behavioural RAM with optional stuck-at cell,
// expected bus trace expanded from the March C- notation.
module tb_march_bist_controller;
    localparam int SIZE   = 6;
    localparam int LENGTH = 8;
    localparam int N      = 64;
    localparam int NCYC   = 10 * N;
    localparam logic [7:0] D0 = 8'hAA;
    localparam logic [7:0] D1 = 8'h55;

    typedef struct {
        bit         rd;
        logic [5:0] addr;
        logic [7:0] data;
        logic [2:0] elem;
    } op_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [5:0] fail_addr;
    logic [2:0] fail_element;

    march_bist_controller_if #(.SIZE(SIZE), .LENGTH(LENGTH)) mif();

    march_bist_controller #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem          (mif),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .fail_addr    (fail_addr),
        .fail_element (fail_element)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; a faulty cell forces one bit on read.
    logic [7:0] ram [N];
    logic       f_en   = 1'b0;
    logic [5:0] f_addr = '0;
    logic [2:0] f_bit  = '0;
    logic       f_val  = 1'b0;
    logic [7:0] rd_raw;

    always_comb begin
        rd_raw = ram[mif.mem_addr];
        if (f_en && (mif.mem_addr == f_addr)) rd_raw[f_bit] = f_val;
        mif.mem_rdata = mif.mem_rwbar ? rd_raw : 8'h00;
    end

    always @(posedge clk) begin
        if (mif.mem_cs && !mif.mem_rwbar) ram[mif.mem_addr] <= mif.mem_wdata;
    end

    string mdef [6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};
    op_t   trace [$];
    bit    fail_before [NCYC];
    int    exp_first;
    logic [5:0] exp_fa;
    logic [2:0] exp_fe;

    int spot_c     [6] = '{0, 64, 65, 320, 321, 575};
    int spot_rwbar [6] = '{0, 1, 0, 1, 0, 0};
    int spot_addr  [6] = '{0, 0, 0, 63, 63, 0};
    int spot_wdata [6] = '{8'hAA, 8'h00, 8'h55, 8'h00, 8'h55, 8'hAA};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("check %s did not match", tag);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {4'b0, busy, done, mif.mem_cs, mif.mem_rwbar, mif.mem_addr, mif.mem_wdata,
                fail, fail_addr, fail_element};
    endfunction

    task automatic build_trace();
        op_t   t;
        string s;
        int    nops;
        bit    dn;
        for (int e = 0; e < 6; e++) begin
            s    = mdef[e];
            dn   = (s.substr(0, 0) == "D");
            nops = (s.len() - 1) / 2;
            for (int k = 0; k < N; k++) begin
                for (int o = 0; o < nops; o++) begin
                    t.rd   = (s.substr(1 + 2*o, 1 + 2*o) == "r");
                    t.data = (s.substr(2 + 2*o, 2 + 2*o) == "1") ? D1 : D0;
                    t.addr = 6'(dn ? (N - 1 - k) : k);
                    t.elem = 3'(e);
                    trace.push_back(t);
                end
            end
        end
    endtask

    // Replays the trace on a model memory with the current fault to find the first mismatch.
    task automatic build_expect();
        logic [7:0] m [N];
        logic [7:0] v;
        exp_first = -1;
        exp_fa    = '0;
        exp_fe    = '0;
        for (int c = 0; c < NCYC; c++) begin
            fail_before[c] = (exp_first >= 0);
            if (!trace[c].rd) begin
                v = trace[c].data;
                if (f_en && (trace[c].addr == f_addr)) v[f_bit] = f_val;
                m[trace[c].addr] = v;
            end else if ((exp_first < 0) && (m[trace[c].addr] !== trace[c].data)) begin
                exp_first = c;
                exp_fa    = trace[c].addr;
                exp_fe    = trace[c].elem;
            end
        end
    endtask

    task automatic idle_delay();
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic do_run(input bit hold, input int abort_c);
        op_t t;
        build_expect();
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            t = trace[c];
            check("run_bus",
                  {13'b0, busy, done, mif.mem_cs, mif.mem_rwbar, mif.mem_addr, mif.mem_wdata, fail},
                  {13'b0, 1'b1, 1'b0, 1'b1, t.rd, t.addr, (t.rd ? 8'h00 : t.data), fail_before[c]});
            for (int k = 0; k < 6; k++) begin
                if (spot_c[k] == c)
                    check("spot_op", {16'b0, mif.mem_rwbar, mif.mem_addr, mif.mem_wdata},
                          {16'b0, spot_rwbar[k][0], spot_addr[k][5:0], spot_wdata[k][7:0]});
            end
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                check("rst_mid", outs_vec(), 32'h0);
                return;
            end
            @(negedge clk);
        end
        check("done_state", {busy, done, mif.mem_cs}, 3'b010);
        check("fail_flag", fail, (exp_first >= 0));
        check("fail_addr", fail_addr, exp_fa);
        check("fail_element", fail_element, exp_fe);
    endtask

    initial begin
        build_trace();

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            #1;
            check("rst_hold", outs_vec(), 32'h0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_after_rst", outs_vec(), 32'h0);
        end

        f_en = 1'b0;
        idle_delay();
        do_run(1'b0, -1);

        f_en = 1'b1; f_addr = 6'd5; f_bit = 3'd0; f_val = 1'b0;
        idle_delay();
        do_run(1'b1, -1);
        check("stuck_fail_addr", fail_addr, 6'd5);
        check("stuck_fail_element", fail_element, 3'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_done", {busy, done, mif.mem_cs}, 3'b010);
        end
        start = 1'b0;
        @(negedge clk);
        check("drop_start", {busy, done, mif.mem_cs}, 3'b000);

        f_en = 1'b0;
        idle_delay();
        do_run(1'b0, -1);

        for (int r = 0; r < 3; r++) begin
            f_en   = 1'b1;
            f_addr = 6'($urandom_range(0, N - 1));
            f_bit  = 3'($urandom_range(0, 7));
            f_val  = 1'($urandom_range(0, 1));
            idle_delay();
            do_run(1'b0, -1);
        end

        f_en = 1'b1; f_addr = 6'd5; f_bit = 3'd0; f_val = 1'b0;
        idle_delay();
        do_run(1'b0, 300);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_hold", outs_vec(), 32'h0);
        end
        @(negedge clk);
        f_en = 1'b0;
        rst  = 1'b1;
        do_run(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/march_bist_controller.md
Name: march_bist_controller

Overview:
- Sequencer for the BIST memory path: runs a March C- test over a 2^SIZE x LENGTH single-port RAM.
- Issues one memory operation per clock and compares read data in the same cycle.
- Reports sticky pass/fail, plus the address and element of the first mismatch.
- Sits between the top-level start/test control and the RAM-side mux that selects between functional and BIST access.

Parameters:
- SIZE, 6, address width; the memory has N = 2^SIZE words.
- LENGTH, 8, data width.
- PATTERN, alternating 1010... with MSB=1 (8'hAA at LENGTH=8), data background "D0"; "D1" = ~PATTERN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  level request to run a test
- mem_rdata  input  LENGTH  RAM read data, combinational from mem_addr when mem_rwbar=1
- mem_cs  output  1  RAM chip select
- mem_rwbar  output  1  1=read, 0=write
- mem_addr  output  SIZE  RAM address
- mem_wdata  output  LENGTH  RAM write data
- busy  output  1  test in progress
- done  output  1  test complete
- fail  output  1  sticky mismatch flag
- fail_addr  output  SIZE  address of first mismatch
- fail_element  output  3  march element index (0-5) of first mismatch

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including mem_cs, mem_rwbar, mem_addr, mem_wdata, busy, done, fail, fail_addr and fail_element.
- Output style: Moore. mem_* outputs decode combinationally from the registered state, element, op and address.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at a posedge moves to RUN. On that edge: clear fail, fail_addr and fail_element; element=0, op=0, addr=0.
  - RUN: busy=1, mem_cs=1. Executes exactly one op per cycle. start is ignored while in RUN.
  - DONE: done=1, busy=0, mem_cs=0; fail and capture registers hold. Moves to IDLE when start=0; stays in DONE while start=1, so there is no auto-restart.
- March sequence ("up" = addr 0 to N-1, "dn" = N-1 to 0):
  - M0 up(w D0)
  - M1 up(r D0, w D1)
  - M2 up(r D1, w D0)
  - M3 dn(r D0, w D1)
  - M4 dn(r D1, w D0)
  - M5 up(r D0)
- Op counter walks the ops of the current element at one address before the address advances.
- Address wrap: after the last op at the final address of an element, advance to the next element. The next start address is 0 for up elements and N-1 for dn elements.
- Total RUN length is 10N cycles (640 at SIZE=6).
- After the last op (M5 read at addr N-1), the next edge enters DONE.
- Reads: expected data = D0 or D1 per the op. A mismatch is sampled at the posedge ending the read cycle and sets fail=1.
  - fail_addr and fail_element capture only on the first mismatch of the run.
  - The test always runs to completion; there is no early abort.
- Writes: mem_wdata = D0 or D1. mem_wdata is 0 during reads and outside RUN.
- Reset mid-run: immediate return to IDLE with all outputs 0. The next start begins a full run from M0, addr 0.
- start and rst deassertion in the same cycle: start is sampled at the first posedge with rst=1.

Test Plan:
- Reset: hold rst=0, toggle start -> all outputs 0, no RAM access; release rst with start=0 -> stays IDLE.
- Fault-free run (SIZE=6, LENGTH=8, behavioural RAM): pulse start -> busy=1 for exactly 640 cycles.
  - RUN cycle 0 writes 8'hAA to addr 0.
  - Cycle 64 reads addr 0; cycle 65 writes 8'h55 to addr 0.
  - Ends with done=1, fail=0.
- Descending order: in the same run, the first M3 op (RUN cycle 320) is a read at addr 63 expecting 8'hAA; cycle 321 writes 8'h55 to addr 63; last M4 op writes addr 0.
- Stuck-at-0 on bit0 of addr 5 in the RAM model -> first mismatch at RUN cycle 202 (M2 read D1=8'h55, got 8'h54).
  - Required: fail=1, fail_addr=5, fail_element=2.
  - Later mismatches (M4 at addr 5) leave fail_addr and fail_element unchanged.
  - done asserts at cycle 640.
- Reset mid-run: drive rst=0 at RUN cycle 300 -> same-cycle mem_cs=0, busy=0.
  - Release rst and restart -> full 640-cycle run from addr 0 with fail cleared.
- Start held high through completion: done stays 1 and no new RUN begins.
  - Drop start -> IDLE, done=0.
  - Raise start -> new run with previous fail capture cleared.
